// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and execute requesters onto one synchronous single-port memory.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  input  logic        ex_req,
  input  logic        ex_we,
  input  logic [7:0]  ex_addr,
  input  logic [15:0] ex_wdata,
  output logic        ex_gnt,
  output logic [15:0] ex_rdata,
  output logic        ex_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_EX, WAIT_IF} stateT;

  stateT state;
  logic  fetchWins;
  logic  inIdle;

  assign inIdle = (state == IDLE) && !rst;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

  logic [CntW-1:0] starveCnt;

  assign fetchWins = if_req && (!ex_req || (starveCnt == CntW'(STARVE_LIMIT)));

  // Only IDLE cycles with a pending, ungranted fetch count as denied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (!if_req || if_gnt) begin
      starveCnt <= '0;
    end else if ((state == IDLE) && (starveCnt != CntW'(STARVE_LIMIT))) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end
`else
  assign fetchWins = if_req && !ex_req;
`endif

  always_comb begin
    if_gnt    = inIdle && fetchWins;
    ex_gnt    = inIdle && ex_req && !fetchWins;
    mem_en    = if_gnt || ex_gnt;
    mem_we    = ex_gnt && ex_we;
    mem_addr  = 8'h00;
    mem_wdata = 16'h0000;
    if (ex_gnt) begin
      mem_addr  = ex_addr;
      mem_wdata = ex_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Read data is captured on leaving WAIT_*, so the valid pulse lands in the
  // IDLE cycle that can issue the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      if_valid <= 1'b0;
      ex_valid <= 1'b0;
      if_rdata <= 16'h0000;
      ex_rdata <= 16'h0000;
    end else begin
      if_valid <= 1'b0;
      ex_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ex_gnt && !ex_we) begin
            state <= WAIT_EX;
          end else if (if_gnt) begin
            state <= WAIT_IF;
          end
        end
        WAIT_EX: begin
          ex_rdata <= mem_rdata;
          ex_valid <= 1'b1;
          state    <= IDLE;
        end
        WAIT_IF: begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ex_req, ex_we;
  logic [7:0]  if_addr, ex_addr;
  logic [15:0] ex_wdata;
  logic        if_gnt, if_valid, ex_gnt, ex_valid;
  logic [15:0] if_rdata, ex_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] mem [256];

  int checks = 0;
  int passes = 0;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int ExpIfCyc    = 3;
  localparam int ExpExBefore = 3;
`else
  localparam int ExpIfCyc    = 5;
  localparam int ExpExBefore = 5;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .ex_req    (ex_req),
    .ex_we     (ex_we),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_gnt    (ex_gnt),
    .ex_rdata  (ex_rdata),
    .ex_valid  (ex_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Advance to just after the next rising edge and apply the inputs for that cycle.
  task automatic drive(input logic ir, input logic [7:0] ia, input logic er, input logic ew,
                       input logic [7:0] ea, input logic [15:0] ed);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; ex_req = er; ex_we = ew; ex_addr = ea; ex_wdata = ed;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 8'h10; ex_req = 1'b1; ex_we = 1'b0;
    ex_addr = 8'h05; ex_wdata = 16'h0000;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b0) $display("FAIL rst_if_gnt: got %b want 0", if_gnt); else passes++;
    checks++; if (ex_gnt !== 1'b0) $display("FAIL rst_ex_gnt: got %b want 0", ex_gnt); else passes++;
    checks++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", mem_en); else passes++;
    checks++; if ({if_valid, ex_valid} !== 2'b00)
      $display("FAIL rst_valid: got %b want 00", {if_valid, ex_valid}); else passes++;
    checks++; if ({if_rdata, ex_rdata} !== 32'h0)
      $display("FAIL rst_rdata: got %h want 0", {if_rdata, ex_rdata}); else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_req = 1'b0; ex_req = 1'b0;
  endtask

  task automatic test_fetch();
    drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if ({if_gnt, ex_gnt, mem_en, mem_we} !== 4'b1010)
      $display("FAIL fetch_gnt: got %b want 1010", {if_gnt, ex_gnt, mem_en, mem_we}); else passes++;
    checks++; if (mem_addr !== 8'h10) $display("FAIL fetch_addr: got %h want 10", mem_addr);
    else passes++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if ({if_gnt, mem_en, if_valid} !== 3'b000)
      $display("FAIL fetch_wait: got %b want 000", {if_gnt, mem_en, if_valid}); else passes++;
    drive(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if ({if_valid, if_gnt} !== 2'b11)
      $display("FAIL fetch_valid_gnt: got %b want 11", {if_valid, if_gnt}); else passes++;
    checks++; if (if_rdata !== 16'h1234) $display("FAIL fetch_rdata: got %h want 1234", if_rdata);
    else passes++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || if_rdata !== 16'h1234)
      $display("FAIL fetch_hold: got %b/%h want 0/1234", if_valid, if_rdata); else passes++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h1111)
      $display("FAIL fetch_second: got %b/%h want 1/1111", if_valid, if_rdata); else passes++;
  endtask

  task automatic test_store_then_fetch();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'h30, 1'b1, 1'b1, 8'h20, 16'hBEEF);
      @(negedge clk);
      checks++; if ({ex_gnt, if_gnt, mem_en, mem_we} !== 4'b1011)
        $display("FAIL store_gnt%0d: got %b want 1011", c, {ex_gnt, if_gnt, mem_en, mem_we});
      else passes++;
      checks++; if (mem_addr !== 8'h20 || mem_wdata !== 16'hBEEF)
        $display("FAIL store_bus%0d: got %h/%h want 20/beef", c, mem_addr, mem_wdata);
      else passes++;
    end
    drive(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if ({if_gnt, ex_gnt, mem_we} !== 3'b100 || mem_addr !== 8'h30)
      $display("FAIL store_fetch: got %b/%h want 100/30", {if_gnt, ex_gnt, mem_we}, mem_addr);
    else passes++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h3030)
      $display("FAIL store_fetch_data: got %b/%h want 1/3030", if_valid, if_rdata); else passes++;
    checks++; if (mem[8'h20] !== 16'hBEEF) $display("FAIL store_mem: got %h want beef", mem[8'h20]);
    else passes++;
  endtask

  // Five stores compete with one fetch; the fetch slot depends on the starvation guard.
  task automatic test_starve_guard();
    int ifCyc = -1;
    int exDone = 0;
    int exBefore = 0;
    int both = 0;
    for (int c = 0; c < 12; c++) begin
      drive(ifCyc < 0, 8'h06, exDone < 5, 1'b1, 8'h21, 16'h0F0F);
      @(negedge clk);
      if (ex_gnt && if_gnt) both++;
      if (ex_gnt) begin
        exDone++;
        if (ifCyc < 0) exBefore++;
      end
      if (if_gnt && ifCyc < 0) ifCyc = c;
    end
    checks++; if (ifCyc != ExpIfCyc) $display("FAIL starve_if_cycle: got %0d want %0d", ifCyc,
      ExpIfCyc); else passes++;
    checks++; if (exBefore != ExpExBefore) $display("FAIL starve_ex_before: got %0d want %0d",
      exBefore, ExpExBefore); else passes++;
    checks++; if (exDone != 5) $display("FAIL starve_ex_total: got %0d want 5", exDone);
    else passes++;
    checks++; if (both != 0) $display("FAIL starve_onehot: got %0d want 0", both); else passes++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic test_load_fetch();
    drive(1'b1, 8'h06, 1'b1, 1'b0, 8'h05, 16'h0000);
    @(negedge clk);
    checks++; if ({ex_gnt, if_gnt, mem_we} !== 3'b100 || mem_addr !== 8'h05)
      $display("FAIL load_gnt: got %b/%h want 100/05", {ex_gnt, if_gnt, mem_we}, mem_addr);
    else passes++;
    drive(1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if ({ex_gnt, if_gnt, mem_en, ex_valid} !== 4'b0000)
      $display("FAIL load_wait: got %b want 0000", {ex_gnt, if_gnt, mem_en, ex_valid}); else passes++;
    drive(1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if ({ex_valid, if_gnt} !== 2'b11 || ex_rdata !== 16'hA005)
      $display("FAIL load_valid: got %b/%h want 11/a005", {ex_valid, if_gnt}, ex_rdata);
    else passes++;
    checks++; if (mem_addr !== 8'h06) $display("FAIL load_fetch_addr: got %h want 06", mem_addr);
    else passes++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if ({if_valid, ex_valid} !== 2'b10 || if_rdata !== 16'hB006 || ex_rdata !== 16'hA005)
      $display("FAIL load_fetch_data: got %b/%h/%h want 10/b006/a005", {if_valid, ex_valid},
        if_rdata, ex_rdata);
    else passes++;
  endtask

  task automatic test_reset_in_wait();
    int sawValid = 0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 16'h0000);
    @(negedge clk);
    checks++; if (ex_gnt !== 1'b1) $display("FAIL rstw_gnt: got %b want 1", ex_gnt); else passes++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    rst = 1'b1;
    ex_req = 1'b1;
    #1;
    checks++; if (ex_rdata !== 16'h0000) $display("FAIL rstw_rdata: got %h want 0000", ex_rdata);
    else passes++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (ex_valid !== 1'b0 || ex_gnt !== 1'b0 || mem_en !== 1'b0) sawValid++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_req = 1'b0;
    @(negedge clk);
    if (ex_valid !== 1'b0) sawValid++;
    checks++; if (sawValid != 0) $display("FAIL rstw_quiet: got %0d want 0", sawValid); else passes++;
    drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) $display("FAIL rstw_resume: got %b want 1", if_gnt); else passes++;
  endtask

  task automatic test_drop_while_busy();
    int busy = 0;
    drive(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    if (if_gnt !== 1'b0 || mem_en !== 1'b0) busy++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h1234)
      $display("FAIL drop_valid: got %b/%h want 1/1234", if_valid, if_rdata); else passes++;
    if (if_gnt !== 1'b0 || mem_en !== 1'b0) busy++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    if (if_gnt !== 1'b0 || mem_en !== 1'b0 || if_valid !== 1'b0) busy++;
    checks++; if (busy != 0) $display("FAIL drop_no_grant: got %0d want 0", busy); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h5A00;
    mem[8'h05] = 16'hA005;
    mem[8'h06] = 16'hB006;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'h1111;
    mem[8'h30] = 16'h3030;
    test_reset();
    test_fetch();
    test_store_then_fetch();
    test_starve_guard();
    test_load_fetch();
    test_reset_in_wait();
    test_drop_while_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
